// File: rtl/gf128_pkg.sv
// Shared constants and types for the GF(2^128) multiplier scheduler.
package gf128_pkg;

  localparam logic [127:0] GF128_POLY_LO = 128'h87;
  localparam int DIGIT_DEFAULT = 8;
  localparam int STEPS = 128 / DIGIT_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gf128_digit_step.sv
// One digit-serial GF(2^128) step: (acc*x^DIGIT ^ a*digit) mod x^128+x^7+x^2+x+1.
module gf128_digit_step
  import gf128_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic [127:0]     acc,
  input  logic [127:0]     a,
  input  logic [DIGIT-1:0] digit,
  output logic [127:0]     acc_next
);

  localparam int W = 128 + DIGIT;
  // x^128 term plus the low taps, so one xor clears an overflow bit
  localparam logic [W-1:0] POLY_FULL = (W'(1'b1) << 128) | W'(GF128_POLY_LO);

  logic [W-1:0] wide_s;

  // Shift-and-add the digit product, then fold the overflow bits back in
  always_comb begin
    wide_s = {acc, {DIGIT{1'b0}}};
    for (int j = 0; j < DIGIT; j++) begin
      if (digit[j]) begin
        wide_s = wide_s ^ (W'(a) << j);
      end else begin
        wide_s = wide_s;
      end
    end
    for (int k = DIGIT - 1; k >= 0; k--) begin
      if (wide_s[128 + k]) begin
        wide_s = wide_s ^ (POLY_FULL << k);
      end else begin
        wide_s = wide_s;
      end
    end
    acc_next = wide_s[127:0];
  end

endmodule

// File: rtl/gf128_mul_sched.sv
// Two-requester round-robin front end for a shared digit-serial GF(2^128) multiplier.
// Optional GF128_ZERO_SKIP_EN: a zero operand bypasses the MUL phase.
module gf128_mul_sched
  import gf128_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_a0,
  input  logic [127:0] req_b0,
  input  logic [127:0] req_a1,
  input  logic [127:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data
);

  localparam int STEPS_C = 128 / DIGIT;
  localparam int CNT_W = $clog2(STEPS_C);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS_C - 1);

  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 || DIGIT == 16) ||
      (128 % DIGIT) != 0) begin : g_digit_check
    $error("gf128_mul_sched: illegal DIGIT");
  end

  state_e             state_r;
  logic               ptr_r;
  logic [127:0]       a_r;
  logic [127:0]       b_r;
  logic               id_r;
  logic [127:0]       acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               rsp_valid_r;
  logic               rsp_id_r;
  logic [127:0]       rsp_data_r;

  logic [1:0]         grant_s;
  logic [1:0]         ready_s;
  logic               accept_s;
  logic [127:0]       sel_a_s;
  logic [127:0]       sel_b_s;
  logic [127:0]       acc_next_s;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer
  always_comb begin
    grant_s = 2'b00;
    if (req_valid == 2'b11) begin
      grant_s = ptr_r ? 2'b10 : 2'b01;
    end else begin
      grant_s = req_valid;
    end
  end

  assign ready_s   = (rst_n && state_r == IDLE) ? grant_s : 2'b00;
  assign accept_s  = |(req_valid & ready_s);
  assign sel_a_s   = grant_s[1] ? req_a1 : req_a0;
  assign sel_b_s   = grant_s[1] ? req_b1 : req_b0;
  assign req_ready = ready_s;

  gf128_digit_step #(.DIGIT(DIGIT)) u_step (
    .acc      (acc_r),
    .a        (a_r),
    .digit    (b_r[127 -: DIGIT]),
    .acc_next (acc_next_s)
  );

  // Scheduler FSM, datapath registers and the registered response port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      id_r        <= 1'b0;
      acc_r       <= '0;
      cnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= sel_a_s;
            b_r   <= sel_b_s;
            id_r  <= grant_s[1];
            acc_r <= '0;
            cnt_r <= '0;
            ptr_r <= ~grant_s[1];
`ifdef GF128_ZERO_SKIP_EN
            if (sel_a_s == 128'd0 || sel_b_s == 128'd0) begin
              rsp_data_r  <= '0;
              rsp_id_r    <= grant_s[1];
              rsp_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= MUL;
            end
`else
            state_r <= MUL;
`endif
          end
        end
        MUL: begin
          // b is consumed MSB-first by shifting the next digit into the top
          acc_r <= acc_next_s;
          b_r   <= b_r << DIGIT;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            rsp_data_r  <= acc_next_s;
            rsp_id_r    <= id_r;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_gf128_mul_sched.sv
// Directed bench for gf128_mul_sched (DIGIT=8) with a bit-serial GF(2^128) reference.
module tb_gf128_mul_sched;
  import gf128_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [127:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [127:0] rsp_data;

  int total = 0;
  int bad = 0;

`ifdef GF128_ZERO_SKIP_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = STEPS;
`endif

  gf128_mul_sched #(.DIGIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] gf_ref(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z = '0;
    logic [127:0] v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) z = z ^ v;
      v = v[127] ? ((v << 1) ^ 128'h87) : (v << 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [127:0] a, input logic [127:0] b);
    if (id == 0) begin
      req_a0 = a; req_b0 = b;
    end else begin
      req_a1 = a; req_b1 = b;
    end
  endtask

  // Present a lone request, wait for its grant and pass the accept edge
  task automatic start_op(input int id, input logic [127:0] a, input logic [127:0] b);
    int n = 0;
    set_ops(id, a, b);
    req_valid = (id == 0) ? 2'b01 : 2'b10;
    #1;
    while (!req_ready[id] && n < 50) begin step(); n++; end
    check("grant", 128'(req_ready[id]), 128'd1);
    step();
    req_valid = 2'b00;
  endtask

  // Edges counted after the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin step(); lat++; end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int id, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] exp, input int exp_lat);
    int lat;
    start_op(id, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_id"}, 128'(rsp_id), 128'(id));
    check({tag, "_data"}, rsp_data, exp);
    handshake();
    check({tag, "_drop"}, 128'(rsp_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] ra[2];
    logic [127:0] rb[2];
    logic [127:0] exp;
    int           n, g, lat, both_hi, seen;

    // reset state, with both requests pending to see req_ready held low
    req_valid = 2'b11;
    step(); step();
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_valid", 128'(rsp_valid), 128'd0);
    check("rst_id", 128'(rsp_id), 128'd0);
    check("rst_data", rsp_data, 128'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    step();

    run_op("ident", 0, 128'h1, 128'hDEADBEEF_00000000_12345678_9ABCDEF0,
           128'hDEADBEEF_00000000_12345678_9ABCDEF0, STEPS);
    run_op("small", 1, 128'h3, 128'h3, 128'h5, STEPS);
    run_op("red_x128", 0, 128'h1 << 127, 128'h2, 128'h87, STEPS);
    run_op("red_x254", 0, 128'h1 << 127, 128'h1 << 127,
           128'hC0000000_00000000_00000000_00001067, STEPS);
    check("ref_x254", gf_ref(128'h1 << 127, 128'h1 << 127),
          128'hC0000000_00000000_00000000_00001067);
    ra[0] = rnd128(); rb[0] = rnd128();
    run_op("rand", 1, ra[0], rb[0], gf_ref(ra[0], rb[0]), STEPS);

    // arbitration from reset with both requesters continuously valid
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin ra[r] = rnd128(); rb[r] = rnd128(); set_ops(r, ra[r], rb[r]); end
    req_valid = 2'b11;
    #1;
    both_hi = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 50) begin step(); n++; end
      if (req_ready == 2'b11) both_hi++;
      g = req_ready[1] ? 1 : 0;
      check("arb_grant", 128'(g), 128'(k % 2));
      exp = gf_ref(ra[g], rb[g]);
      step();
      ra[g] = rnd128(); rb[g] = rnd128(); set_ops(g, ra[g], rb[g]);
      n = 0;
      while (!rsp_valid && n < 200) begin
        if (req_ready == 2'b11) both_hi++;
        step(); n++;
      end
      check("arb_id", 128'(rsp_id), 128'(k % 2));
      check("arb_data", rsp_data, exp);
      handshake();
    end
    req_valid = 2'b00;
    check("arb_onehot", 128'(both_hi), 128'd0);
    step();

    // backpressure: response held while req1 waits
    ra[0] = rnd128(); rb[0] = rnd128(); exp = gf_ref(ra[0], rb[0]);
    start_op(0, ra[0], rb[0]);
    wait_rsp(lat);
    ra[1] = rnd128(); rb[1] = rnd128(); set_ops(1, ra[1], rb[1]);
    req_valid = 2'b10;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 128'(rsp_valid), 128'd1);
      check("bp_data", rsp_data, exp);
      check("bp_id", 128'(rsp_id), 128'd0);
      check("bp_ready", 128'(req_ready), 128'd0);
      step();
    end
    handshake();
    #1;
    check("bp_after_valid", 128'(rsp_valid), 128'd0);
    check("bp_after_ready", 128'(req_ready), 128'b10);
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    check("bp_next_lat", 128'(lat), 128'(STEPS));
    check("bp_next_id", 128'(rsp_id), 128'd1);
    check("bp_next_data", rsp_data, gf_ref(ra[1], rb[1]));
    handshake();

    // reset during MUL step 7 of a req0 operation, then req1 alone
    start_op(0, rnd128(), rnd128());
    for (int c = 0; c < 6; c++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) seen++;
      step();
    end
    check("abort_no_rsp", 128'(seen), 128'd0);
    ra[1] = rnd128(); rb[1] = rnd128();
    run_op("abort_req1", 1, ra[1], rb[1], gf_ref(ra[1], rb[1]), STEPS);

    // a second abort after a req0 accept: the pointer must favour requester 0 again
    start_op(0, rnd128(), rnd128());
    for (int c = 0; c < 6; c++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("abort_ptr", 128'(req_ready), 128'b01);
    req_valid = 2'b00;
    step();

    // zero operands
    rb[0] = rnd128() | 128'h1;
    run_op("zero_a", 0, 128'h0, rb[0], 128'h0, ZERO_LAT);
    ra[1] = rnd128() | 128'h1;
    run_op("zero_b", 1, ra[1], 128'h0, 128'h0, ZERO_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
